// File: rtl/text_buffer.sv
// Character-cell text buffer: COLS*ROWS x 16 cell RAM, 16-entry RGB444
// palette, hardware clear engine and a 2-stage scrolled read pipeline
// feeding the glyph/colour display stage.
module text_buffer #(
  parameter int unsigned COLS = 80,
  parameter int unsigned ROWS = 60
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [12:0] wr_addr,
  input  logic [15:0] wr_data,
  input  logic        pal_we,
  input  logic [3:0]  pal_idx,
  input  logic [11:0] pal_color,
  input  logic        clr_req,
  input  logic [15:0] clr_data,
  output logic        busy,
  input  logic [5:0]  scroll,
  input  logic [6:0]  rd_col,
  input  logic [5:0]  rd_row,
  output logic [6:0]  char,
  output logic        flip,
  output logic [11:0] on,
  output logic [11:0] off
);

  localparam int unsigned DEPTH   = COLS * ROWS;
  localparam logic [19:0] DEPTH_W = 20'(DEPTH);
  localparam logic [19:0] COLS_W  = 20'(COLS);
  localparam logic [19:0] ROWS_W  = 20'(ROWS);
  localparam logic [12:0] LAST    = 13'(DEPTH - 1);

  typedef enum logic {IDLE, CLEAR} state_e;

  state_e      state_q, state_d;
  logic [12:0] cnt_q, cnt_d;
  logic [15:0] clr_word_q, clr_word_d;
  logic        wr_ready_q, busy_q;

  logic        mem_we;
  logic [12:0] mem_waddr;
  logic [15:0] mem_wdata;

  logic [15:0] mem [DEPTH];
  logic [11:0] pal_q [16];

  logic [19:0] row_sum, phys_row, rd_lin;
  logic [12:0] rd_idx;
  logic        rd_oob_d, rd_oob_q;
  logic [15:0] cell_q;

  logic [6:0]  char_d, char_q;
  logic        flip_d, flip_q;
  logic [11:0] on_d, on_q, off_d, off_q;

  // Next-state, clear counter and the single RAM write port arbitration
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    clr_word_d = clr_word_q;
    mem_we     = 1'b0;
    mem_waddr  = wr_addr;
    mem_wdata  = wr_data;
    unique case (state_q)
      IDLE: begin
        // host write in the same cycle as clr_req lands before the clear
        if (wr_valid && wr_ready_q && (20'(wr_addr) < DEPTH_W)) mem_we = 1'b1;
        if (clr_req) begin
          state_d    = CLEAR;
          cnt_d      = '0;
          clr_word_d = clr_data;
        end
      end
      CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = cnt_q;
        mem_wdata = clr_word_q;
        cnt_d     = cnt_q + 13'd1;
        if (cnt_q == LAST) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM registers with registered handshake/status outputs
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= CLEAR;
      cnt_q      <= '0;
      clr_word_q <= 16'h0F20;
      wr_ready_q <= 1'b0;
      busy_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      clr_word_q <= clr_word_d;
      wr_ready_q <= (state_d == IDLE);
      busy_q     <= (state_d == CLEAR);
    end
  end

  // Scrolled row wrap and linear read address
  always_comb begin
    row_sum  = 20'(rd_row) + 20'(scroll);
    phys_row = (row_sum >= ROWS_W) ? (row_sum - ROWS_W) : row_sum;
    rd_lin   = phys_row * COLS_W + 20'(rd_col);
    rd_oob_d = (20'(rd_col) >= COLS_W) || (20'(rd_row) >= ROWS_W);
    rd_idx   = (rd_lin < DEPTH_W) ? rd_lin[12:0] : '0;
  end

  // Cell RAM: read-before-write so a colliding read sees the old word
  always_ff @(posedge clock) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
    cell_q <= mem[rd_idx];
  end

  // Out-of-range flag travels alongside the RAM read stage
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) rd_oob_q <= 1'b1;
    else          rd_oob_q <= rd_oob_d;
  end

  // Palette: reset to a grey ramp, written whenever pal_we is high
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < 16; i++) pal_q[i] <= {4'(i), 4'(i), 4'(i)};
    end else if (pal_we) begin
      pal_q[pal_idx] <= pal_color;
    end
  end

  // Second stage decode: field split and palette lookup
  always_comb begin
    char_d = '0;
    flip_d = 1'b0;
    on_d   = '0;
    off_d  = '0;
    if (!rd_oob_q) begin
      char_d = cell_q[6:0];
      flip_d = cell_q[7];
      on_d   = pal_q[cell_q[11:8]];
      off_d  = pal_q[cell_q[15:12]];
    end
  end

  // Registered display outputs
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      char_q <= '0;
      flip_q <= 1'b0;
      on_q   <= '0;
      off_q  <= '0;
    end else begin
      char_q <= char_d;
      flip_q <= flip_d;
      on_q   <= on_d;
      off_q  <= off_d;
    end
  end

  assign wr_ready = wr_ready_q;
  assign busy     = busy_q;
  assign char     = char_q;
  assign flip     = flip_q;
  assign on       = on_q;
  assign off      = off_q;

endmodule

// File: tb/tb_text_buffer.sv
// Self-checking bench for text_buffer against a behavioural cell/palette model.
module tb_text_buffer;

  localparam int COLS = 80;
  localparam int ROWS = 60;
  localparam int N    = COLS * ROWS;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [12:0] wr_addr = '0;
  logic [15:0] wr_data = '0;
  logic        pal_we = 1'b0;
  logic [3:0]  pal_idx = '0;
  logic [11:0] pal_color = '0;
  logic        clr_req = 1'b0;
  logic [15:0] clr_data = '0;
  logic        busy;
  logic [5:0]  scroll = '0;
  logic [6:0]  rd_col = '0;
  logic [5:0]  rd_row = 6'd63;
  logic [6:0]  char;
  logic        flip;
  logic [11:0] on;
  logic [11:0] off;

  int checks = 0;
  int errors = 0;

  logic [15:0] model_mem [N];
  logic [11:0] model_pal [16];
  bit          m_oob;
  logic [15:0] m_cell;
  bit          m_ready;

  always #5 clock = ~clock;

  text_buffer #(.COLS(COLS), .ROWS(ROWS)) dut (
    .clock(clock), .reset_n(reset_n),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .pal_we(pal_we), .pal_idx(pal_idx), .pal_color(pal_color),
    .clr_req(clr_req), .clr_data(clr_data), .busy(busy),
    .scroll(scroll), .rd_col(rd_col), .rd_row(rd_row),
    .char(char), .flip(flip), .on(on), .off(off)
  );

  function automatic logic [31:0] decode(input bit oob, input logic [15:0] c);
    if (oob) return 32'h0;
    return {c[6:0], c[7], model_pal[c[11:8]], model_pal[c[15:12]]};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) model_pal[i] = {4'(i), 4'(i), 4'(i)};
    m_oob   = 1'b1;
    m_cell  = '0;
    m_ready = 1'b0;
  endtask

  task automatic model_fill(input logic [15:0] w);
    for (int i = 0; i < N; i++) model_mem[i] = w;
  endtask

  // One clock: predict the display word emerging after this edge, advance model
  task automatic tick(output logic [31:0] e, output logic [31:0] o);
    int r, c;
    e = decode(m_oob, m_cell);
    r = int'(rd_row);
    c = int'(rd_col);
    if (c >= COLS || r >= ROWS) begin
      m_oob  = 1'b1;
      m_cell = '0;
    end else begin
      m_oob  = 1'b0;
      m_cell = model_mem[((r + int'(scroll)) % ROWS) * COLS + c];
    end
    if (wr_valid && m_ready && int'(wr_addr) < N) model_mem[int'(wr_addr)] = wr_data;
    if (pal_we) model_pal[pal_idx] = pal_color;
    @(posedge clock);
    #1;
    o = {char, flip, on, off};
  endtask

  task automatic test_reset();
    logic [31:0] e, o;
    int cnt;
    reset_n = 1'b0;
    model_reset();
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if ({char, flip, on, off} !== 32'h0) begin
      errors++; $display("FAIL reset_outputs: got %h expected %h", {char, flip, on, off}, 32'h0);
    end
    checks++;
    if (wr_ready !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL reset_status: got ready=%b busy=%b expected ready=0 busy=1", wr_ready, busy);
    end
    reset_n = 1'b1;
    cnt = 0;
    do begin tick(e, o); cnt++; end while (busy === 1'b1 && cnt < 6000);
    checks++;
    if (cnt != N) begin
      errors++; $display("FAIL powerup_clear_len: got %0d expected %0d", cnt, N);
    end
    model_fill(16'h0F20);
    m_ready = 1'b1;
    checks++;
    if (wr_ready !== 1'b1) begin
      errors++; $display("FAIL powerup_ready: got %b expected 1", wr_ready);
    end
    rd_col = 7'd0; rd_row = 6'd0;
    tick(e, o); tick(e, o);
    checks++;
    if (o !== {7'h20, 1'b0, 12'hFFF, 12'h000} || o !== e) begin
      errors++; $display("FAIL powerup_cell0: got %h expected %h", o, {7'h20, 1'b0, 12'hFFF, 12'h000});
    end
  endtask

  task automatic test_write_read();
    logic [31:0] e, o;
    rd_row = 6'd63;
    wr_valid = 1'b1; wr_addr = 13'd81; wr_data = 16'h3A41;
    tick(e, o);
    wr_valid = 1'b0;
    rd_col = 7'd1; rd_row = 6'd1;
    tick(e, o); tick(e, o);
    checks++;
    if (o !== {7'h41, 1'b0, 12'hAAA, 12'h333} || o !== e) begin
      errors++; $display("FAIL write_read_81: got %h expected %h", o, {7'h41, 1'b0, 12'hAAA, 12'h333});
    end
  endtask

  task automatic test_scroll();
    logic [31:0] e, o;
    wr_valid = 1'b1; wr_addr = 13'd0; wr_data = 16'h2C15;
    tick(e, o);
    wr_valid = 1'b0;
    scroll = 6'd59; rd_row = 6'd1; rd_col = 7'd0;
    tick(e, o); tick(e, o);
    checks++;
    if (o !== {7'h15, 1'b0, 12'hCCC, 12'h222} || o !== e) begin
      errors++; $display("FAIL scroll_wrap: got %h expected %h", o, {7'h15, 1'b0, 12'hCCC, 12'h222});
    end
    scroll = 6'd0; rd_row = 6'd60;
    tick(e, o); tick(e, o);
    checks++;
    if (o !== 32'h0 || o !== e) begin
      errors++; $display("FAIL row_oob: got %h expected %h", o, 32'h0);
    end
    rd_row = 6'd0; rd_col = 7'd80;
    tick(e, o); tick(e, o);
    checks++;
    if (o !== 32'h0 || o !== e) begin
      errors++; $display("FAIL col_oob: got %h expected %h", o, 32'h0);
    end
    rd_row = 6'd59; rd_col = 7'd79;
    tick(e, o); tick(e, o);
    checks++;
    if (o !== {7'h20, 1'b0, 12'hFFF, 12'h000} || o !== e) begin
      errors++; $display("FAIL last_cell: got %h expected %h", o, {7'h20, 1'b0, 12'hFFF, 12'h000});
    end
  endtask

  task automatic test_pal_collision();
    logic [31:0] e, o;
    wr_valid = 1'b1; wr_addr = 13'd0; wr_data = 16'h0A41;
    tick(e, o);
    wr_valid = 1'b0;
    scroll = 6'd0; rd_row = 6'd0; rd_col = 7'd0;
    tick(e, o); tick(e, o); tick(e, o);
    checks++;
    if (o[23:12] !== 12'hAAA || o !== e) begin
      errors++; $display("FAIL pal_before: got %h expected %h", o[23:12], 12'hAAA);
    end
    pal_we = 1'b1; pal_idx = 4'd10; pal_color = 12'hF00;
    tick(e, o);
    pal_we = 1'b0;
    checks++;
    if (o[23:12] !== 12'hAAA || o !== e) begin
      errors++; $display("FAIL pal_same_cycle: got %h expected %h", o[23:12], 12'hAAA);
    end
    tick(e, o);
    checks++;
    if (o[23:12] !== 12'hF00 || o !== e) begin
      errors++; $display("FAIL pal_next_cycle: got %h expected %h", o[23:12], 12'hF00);
    end
  endtask

  task automatic test_random();
    logic [31:0] e, o;
    int ra;
    for (int i = 0; i < 800; i++) begin
      rd_col = 7'($urandom_range(0, 84));
      rd_row = 6'($urandom_range(0, 62));
      scroll = 6'($urandom_range(0, ROWS - 1));
      wr_valid = 1'($urandom_range(0, 1));
      wr_data = 16'($urandom);
      if ($urandom_range(0, 9) == 0) wr_addr = 13'($urandom_range(N, 8191));
      else                           wr_addr = 13'($urandom_range(0, N - 1));
      if (int'(rd_col) < COLS && int'(rd_row) < ROWS && $urandom_range(0, 3) == 0) begin
        ra = ((int'(rd_row) + int'(scroll)) % ROWS) * COLS + int'(rd_col);
        wr_addr = 13'(ra);
      end
      pal_we = ($urandom_range(0, 3) == 0);
      pal_idx = 4'($urandom);
      pal_color = 12'($urandom);
      tick(e, o);
      checks++;
      if (o !== e) begin
        errors++; $display("FAIL random_read[%0d]: got %h expected %h", i, o, e);
      end
    end
    wr_valid = 1'b0; pal_we = 1'b0; scroll = 6'd0;
  endtask

  task automatic test_clear_with_write();
    logic [31:0] e, o;
    int cnt;
    rd_row = 6'd63;
    wr_valid = 1'b1; wr_addr = 13'd100; wr_data = 16'hBEEF;
    clr_req = 1'b1; clr_data = 16'h1234;
    tick(e, o);
    wr_valid = 1'b0; clr_req = 1'b0;
    m_ready = 1'b0;
    checks++;
    if (wr_ready !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL clear_start: got ready=%b busy=%b expected ready=0 busy=1", wr_ready, busy);
    end
    rd_row = 6'd1; rd_col = 7'd20;
    cnt = 0;
    do begin
      tick(e, o);
      cnt++;
      if (cnt == 2) begin
        checks++;
        if (o !== e || o[31:25] !== 7'h6F) begin
          errors++; $display("FAIL clr_cycle_write: got %h expected %h", o, e);
        end
        rd_row = 6'd63;
      end
      if (cnt == 100) begin clr_req = 1'b1; clr_data = 16'hFFFF; end
      if (cnt == 101) clr_req = 1'b0;
      if (cnt == 200) begin wr_valid = 1'b1; wr_addr = 13'd5; wr_data = 16'hDEAD; end
      if (cnt == 201) wr_valid = 1'b0;
    end while (wr_ready !== 1'b1 && cnt < 6000);
    checks++;
    if (cnt != N) begin
      errors++; $display("FAIL clear_len: got %0d expected %0d", cnt, N);
    end
    model_fill(16'h1234);
    m_ready = 1'b1;
    for (int a = 0; a < N + 2; a++) begin
      rd_row = 6'((a < N ? a : 0) / COLS);
      rd_col = 7'((a < N ? a : 0) % COLS);
      tick(e, o);
      checks++;
      if (o !== e) begin
        errors++; $display("FAIL clear_readback[%0d]: got %h expected %h", a, o, e);
      end
    end
  endtask

  task automatic test_reset_mid_clear();
    logic [31:0] e, o;
    int cnt;
    rd_row = 6'd63;
    clr_req = 1'b1; clr_data = 16'h5555;
    tick(e, o);
    clr_req = 1'b0;
    m_ready = 1'b0;
    rd_row = 6'd58; rd_col = 7'd60;
    for (int i = 0; i < 2000; i++) tick(e, o);
    checks++;
    if (o !== e || o !== {7'h34, 1'b0, model_pal[2], model_pal[1]}) begin
      errors++; $display("FAIL pre_reset_read: got %h expected %h", o, e);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({char, flip, on, off} !== 32'h0 || wr_ready !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL mid_reset: got out=%h ready=%b busy=%b expected out=0 ready=0 busy=1",
                         {char, flip, on, off}, wr_ready, busy);
    end
    model_reset();
    rd_row = 6'd63;
    @(posedge clock); @(posedge clock);
    #1;
    reset_n = 1'b1;
    cnt = 0;
    do begin tick(e, o); cnt++; end while (busy === 1'b1 && cnt < 6000);
    checks++;
    if (cnt != N) begin
      errors++; $display("FAIL restart_clear_len: got %0d expected %0d", cnt, N);
    end
    model_fill(16'h0F20);
    m_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      rd_row = (k == 0) ? 6'd0 : (k == 1) ? 6'd31 : 6'd58;
      rd_col = (k == 0) ? 7'd0 : (k == 1) ? 7'd20 : 7'd60;
      tick(e, o); tick(e, o);
      checks++;
      if (o !== {7'h20, 1'b0, 12'hFFF, 12'h000} || o !== e) begin
        errors++; $display("FAIL restart_cell[%0d]: got %h expected %h", k, o, {7'h20, 1'b0, 12'hFFF, 12'h000});
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_scroll();
    test_pal_collision();
    test_random();
    test_clear_with_write();
    test_reset_mid_clear();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/text_buffer.md
TEXT_BUFFER -- requirements
Module: text_buffer

Interface
REQ-001 SHALL have parameter COLS, default 80, meaning characters per row.
REQ-002 SHALL have parameter ROWS, default 60, meaning character rows; COLS*ROWS SHALL be at most 8192.
REQ-003 SHALL have port clock, input, 1, the single clock; every register SHALL be on its rising edge.
REQ-004 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port wr_valid, input, 1, host cell-write request.
REQ-006 SHALL have port wr_ready, output, 1, high when a host write can be accepted.
REQ-007 SHALL have port wr_addr, input, 13, linear cell index (row*COLS+col).
REQ-008 SHALL have port wr_data, input, 16, cell word: [6:0] char, [7] flip, [11:8] fg index, [15:12] bg index.
REQ-009 SHALL have port pal_we, input, 1, palette write strobe.
REQ-010 SHALL have port pal_idx, input, 4, palette entry index.
REQ-011 SHALL have port pal_color, input, 12, RGB444 palette value.
REQ-012 SHALL have port clr_req, input, 1, start-clear pulse.
REQ-013 SHALL have port clr_data, input, 16, fill word for a clear.
REQ-014 SHALL have port busy, output, 1, high while a clear runs.
REQ-015 SHALL have port scroll, input, 6, first displayed row (0..ROWS-1).
REQ-016 SHALL have port rd_col, input, 7, display column request.
REQ-017 SHALL have port rd_row, input, 6, display row request.
REQ-018 SHALL have ports char (output, 7), flip (output, 1), on (output, 12), off (output, 12), the registered glyph code, mirror bit, fg colour and bg colour feeding the display stage.

Function
REQ-019 SHALL hold a COLS*ROWS x 16 cell RAM (not reset) and a 16 x 12 palette.
REQ-020 SHALL compute the physical row as rd_row+scroll, minus ROWS if the sum is at least ROWS, then form the address as physical_row*COLS+rd_col.
REQ-021 SHALL return read data with 2-cycle latency: cycle 1 RAM read; cycle 2 register char, flip, on=palette[fg], off=palette[bg].
REQ-022 SHALL accept a read every cycle, independent of writes and of the clear.
REQ-023 SHALL return the old RAM contents when a read and a write hit the same cell in the same cycle.
REQ-024 SHALL return the old colour when a palette write and a palette lookup hit the same entry in the same cycle.
REQ-025 SHALL register rd_col>=COLS or rd_row>=ROWS as char=0, flip=0, on=0, off=0.
REQ-026 SHALL write a host cell only on a cycle where wr_valid and wr_ready are both high.
REQ-027 SHALL drop an accepted host write with wr_addr>=COLS*ROWS, with no effect.
REQ-028 SHALL apply a palette write on the cycle pal_we is high, regardless of state.
REQ-029 SHALL use FSM states IDLE and CLEAR; wr_ready=1 only in IDLE; busy=1 only in CLEAR.
REQ-030 SHALL go IDLE->CLEAR when clr_req=1 in IDLE: latch clr_data, set counter to 0; any host write that cycle SHALL be accepted and performed first.
REQ-031 SHALL, in CLEAR, write the latched word to cell[counter] each cycle, incrementing the counter; on the write to COLS*ROWS-1 it SHALL return to IDLE next cycle (clear = COLS*ROWS cycles).
REQ-032 SHALL ignore clr_req while in CLEAR.

Reset
REQ-033 SHALL, while reset_n=0, force char=0, flip=0, on=0, off=0, wr_ready=0, busy=1, state CLEAR, counter 0, clear word 16'h0F20.
REQ-034 SHALL set palette entry i to {i,i,i} on reset.
REQ-035 SHALL start the power-up clear on the first clock after reset_n rises; reset asserted mid-clear SHALL restart it from cell 0.

Verification
REQ-036 Release reset -> busy high 4800 cycles, then wr_ready=1; read (0,0) gives char=7'h20, on=12'hFFF, off=12'h000.
REQ-037 Write addr 81 data 16'h3A41, then read col 1 row 1 -> 2 cycles later char=7'h41, flip=0, on=12'hAAA, off=12'h333.
REQ-038 Set scroll=59, read row 1 col 0 -> returns cell at address 0; scroll=0, read row 60 -> all zeros.
REQ-039 clr_req with clr_data 16'h1234 plus wr_valid same cycle -> write done, wr_ready low 4800 cycles, then every cell reads 16'h1234.
REQ-040 pal_we idx 10 colour 12'hF00 while reading a cell with fg 10 -> same-cycle lookup gives old 12'hAAA, next gives 12'hF00.
REQ-041 Assert reset_n=0 at clear cycle 2000 -> outputs reset at once; clear restarts at 0 and busy lasts 4800 cycles.
